// File: rtl/expr_eval_sched_pkg.sv
// Shared types and widths for the expression-evaluator scheduler.
// Operand bundle layout, MSB first: {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}.
package expr_eval_sched_pkg;

  localparam int A0_W = 4;
  localparam int A1_W = 5;
  localparam int A2_W = 6;
  localparam int A3_W = 4;
  localparam int A4_W = 5;
  localparam int A5_W = 6;
  localparam int B0_W = 4;
  localparam int B1_W = 5;
  localparam int B2_W = 6;
  localparam int B3_W = 4;
  localparam int B4_W = 5;
  localparam int B5_W = 6;

  localparam int OP_W  = A0_W + A1_W + A2_W + A3_W + A4_W + A5_W
                       + B0_W + B1_W + B2_W + B3_W + B4_W + B5_W;
  localparam int RES_W = 90;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/expr_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
// Produces a one-hot grant and its index; grant is zero when en is low.
module expr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NREQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/expr_eval_sched.sv
// Round-robin scheduler sharing one combinational expression evaluator among NREQ requesters.
// Optional per-requester completion counters are built when EXPR_EVAL_SCHED_STATS_EN is defined.
//
// Handshakes: req_ready[i] is a combinational accept strobe; a request transfers on the
// rising edge where req_valid[i] & req_ready[i]. The response transfers on the edge where
// rsp_valid & rsp_ready; rsp_id/rsp_y hold steady while rsp_valid is high and rsp_ready low.
module expr_eval_sched
  import expr_eval_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int EVAL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*OP_W-1:0]       req_op,
  output logic [NREQ-1:0]            req_ready,
  output logic [OP_W-1:0]            eval_op,
  input  logic [RES_W-1:0]           eval_y,
  output logic                       eval_busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [RES_W-1:0]           rsp_y,
  output logic [NREQ*16-1:0]         stat_cnt,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(NREQ)-1:0]    dbg_rr_ptr
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0]  eval_op_q;
  logic [RES_W-1:0] rsp_y_q;
  logic [ID_W-1:0]  id_q;

  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [OP_W-1:0]  op_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_op_split
    assign op_arr[i] = req_op[i*OP_W +: OP_W];
  end

  expr_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (state_q == IDLE),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

  // The operand register stays put after completion; it only changes on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      eval_op_q <= '0;
      rsp_y_q   <= '0;
      id_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            eval_op_q <= op_arr[gnt_idx];
            id_q      <= gnt_idx;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= CNT_W'(EVAL_LAT - 1);
            state_q   <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            rsp_y_q <= eval_y;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = gnt;
  assign eval_op    = eval_op_q;
  assign eval_busy  = (state_q == DRIVE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_y      = rsp_y_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

`ifdef EXPR_EVAL_SCHED_STATS_EN
  logic [15:0] stat_q [NREQ];
  logic        rsp_fire;

  assign rsp_fire = (state_q == RESP) && rsp_ready;

  // 16-bit counters wrap naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_q[i] <= '0;
      end
    end else if (rsp_fire) begin
      stat_q[id_q] <= stat_q[id_q] + 16'd1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat_out
    assign stat_cnt[i*16 +: 16] = stat_q[i];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_expr_eval_sched.sv
// Bench for expr_eval_sched: three instances (EVAL_LAT 1, 3, 4) share the request/response
// inputs and are each checked every cycle against a transaction-level timing model.
module tb_expr_eval_sched;

  localparam int NREQ  = 4;
  localparam int OP_W  = 60;
  localparam int RES_W = 90;
  localparam int NINST = 3;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*OP_W-1:0] req_op    = '0;
  logic                 rsp_ready = 1'b0;

  logic [NREQ-1:0]  rdy  [NINST];
  logic [OP_W-1:0]  eop  [NINST];
  logic [RES_W-1:0] evy  [NINST];
  logic [RES_W-1:0] ry   [NINST];
  logic             busy [NINST];
  logic             rv   [NINST];
  logic [1:0]       rid  [NINST];
  logic [63:0]      stat [NINST];
  logic [1:0]       dst  [NINST];
  logic [1:0]       dptr [NINST];

  int lat_c [NINST] = '{1, 3, 4};

  // Reference evaluator: any fixed function of the operand fields serves as the shared datapath.
  function automatic logic [RES_W-1:0] eval_fn(input logic [OP_W-1:0] op);
    int s;
    s = int'(op[59:56]) * int'(op[29:26]) + int'(op[55:51]) * int'(op[25:21])
      + int'(op[50:45]) * int'(op[20:15]) + int'(op[44:41]) * int'(op[14:11])
      + int'(op[40:36]) * int'(op[10:6])  + int'(op[35:30]) * int'(op[5:0]);
    return {op ^ {op[29:0], op[59:30]}, s[29:0]};
  endfunction

  for (genvar k = 0; k < NINST; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    assign evy[k] = eval_fn(eop[k]);
    expr_eval_sched #(
      .NREQ     (NREQ),
      .EVAL_LAT (LAT)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_ready  (rdy[k]),
      .eval_op    (eop[k]),
      .eval_y     (evy[k]),
      .eval_busy  (busy[k]),
      .rsp_valid  (rv[k]),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rid[k]),
      .rsp_y      (ry[k]),
      .stat_cnt   (stat[k]),
      .dbg_state  (dst[k]),
      .dbg_rr_ptr (dptr[k])
    );
  end

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Stimulus staged here and applied at the falling edge.
  logic [NREQ-1:0]      nxt_valid = '0;
  logic [NREQ*OP_W-1:0] nxt_op    = '0;
  logic                 nxt_ready = 1'b1;

  // Reference model state, one slot per instance.
  int              m_cyc = 0;
  int              m_ptr    [NINST];
  bit              m_busy   [NINST];
  int              m_rsp_at [NINST];
  logic [OP_W-1:0] m_op     [NINST];
  logic [15:0]     m_stat   [NINST][NREQ];
  int              hs_cnt   [NINST];
  int              acc0_cnt [NINST];
  int              glog_id  [NINST][16];
  int              glog_cyc [NINST][16];
  int              glog_n   [NINST];
  logic [RES_W+1:0] exp_q0[$];
  logic [RES_W+1:0] exp_q1[$];
  logic [RES_W+1:0] exp_q2[$];

  task automatic q_push(input int k, input logic [RES_W+1:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k, output logic [RES_W+1:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (k)
      0: if (exp_q0.size() > 0) v = exp_q0.pop_front(); else ok = 1'b0;
      1: if (exp_q1.size() > 0) v = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) v = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int k = 0; k < NINST; k++) begin
      m_ptr[k] = 0; m_busy[k] = 1'b0; m_rsp_at[k] = 0; m_op[k] = '0;
      hs_cnt[k] = 0; acc0_cnt[k] = 0; glog_n[k] = 0;
      for (int r = 0; r < NREQ; r++) m_stat[k][r] = '0;
    end
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
  endtask

  // Compare one instance against the timing rules for this cycle, then advance the model.
  task automatic check_inst(input int k);
    logic [NREQ-1:0]  exp_rdy;
    logic [1:0]       li;
    logic [RES_W+1:0] head;
    logic [63:0]      exp_stat;
    logic             exp_rv, exp_busy;
    bit               ok;
    int               g;
    exp_rdy = '0;
    g = -1;
    if (!m_busy[k]) begin
      for (int j = 0; j < NREQ; j++) begin
        li = 2'((m_ptr[k] + j) % NREQ);
        if (g < 0 && req_valid[li]) g = int'(li);
      end
    end
    if (g >= 0) exp_rdy[2'(g)] = 1'b1;
    exp_rv   = m_busy[k] && (m_cyc >= m_rsp_at[k]);
    exp_busy = m_busy[k] && !exp_rv;
`ifdef EXPR_EVAL_SCHED_STATS_EN
    exp_stat = {m_stat[k][3], m_stat[k][2], m_stat[k][1], m_stat[k][0]};
`else
    exp_stat = 64'h0;
`endif
    check_cnt++;
    if (rdy[k] !== exp_rdy) $display("FAIL req_ready inst%0d cyc%0d got %b exp %b", k, m_cyc, rdy[k], exp_rdy);
    else pass_cnt++;
    check_cnt++;
    if (rv[k] !== exp_rv) $display("FAIL rsp_valid inst%0d cyc%0d got %b exp %b", k, m_cyc, rv[k], exp_rv);
    else pass_cnt++;
    check_cnt++;
    if (busy[k] !== exp_busy) $display("FAIL eval_busy inst%0d cyc%0d got %b exp %b", k, m_cyc, busy[k], exp_busy);
    else pass_cnt++;
    check_cnt++;
    if (int'(dptr[k]) != m_ptr[k]) $display("FAIL rr_ptr inst%0d cyc%0d got %0d exp %0d", k, m_cyc, dptr[k], m_ptr[k]);
    else pass_cnt++;
    check_cnt++;
    if (stat[k] !== exp_stat) $display("FAIL stat_cnt inst%0d cyc%0d got %h exp %h", k, m_cyc, stat[k], exp_stat);
    else pass_cnt++;
    if (m_busy[k]) begin
      check_cnt++;
      if (eop[k] !== m_op[k]) $display("FAIL eval_op inst%0d cyc%0d got %h exp %h", k, m_cyc, eop[k], m_op[k]);
      else pass_cnt++;
    end
    if (exp_rv && rv[k] === 1'b1) begin
      head = (k == 0) ? exp_q0[0] : ((k == 1) ? exp_q1[0] : exp_q2[0]);
      check_cnt++;
      if ({rid[k], ry[k]} !== head) $display("FAIL rsp_data inst%0d cyc%0d got %0d/%h exp %0d/%h", k, m_cyc, rid[k], ry[k], head[RES_W+1:RES_W], head[RES_W-1:0]);
      else pass_cnt++;
      if (rsp_ready) begin
        q_pop(k, head, ok);
        m_busy[k] = 1'b0;
        hs_cnt[k]++;
        m_stat[k][head[RES_W+1:RES_W]] = m_stat[k][head[RES_W+1:RES_W]] + 16'd1;
      end
    end
    if (g >= 0) begin
      m_op[k] = OP_W'(req_op >> (OP_W * g));
      q_push(k, {2'(g), eval_fn(m_op[k])});
      m_ptr[k]    = (g + 1) % NREQ;
      m_busy[k]   = 1'b1;
      m_rsp_at[k] = m_cyc + lat_c[k] + 1;
      if (g == 0) acc0_cnt[k]++;
      if (glog_n[k] < 16) begin
        glog_id[k][glog_n[k]]  = g;
        glog_cyc[k][glog_n[k]] = m_cyc;
        glog_n[k]++;
      end
    end
  endtask

  // mode 0: staged inputs as-is; 1: fresh random operands; 2: everything random.
  task automatic step(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mode >= 1) begin
        for (int l = 0; l < NREQ; l++) nxt_op[l*OP_W +: OP_W] = OP_W'({$urandom(), $urandom()});
      end
      if (mode == 2) begin
        nxt_valid = NREQ'($urandom_range(0, 15));
        nxt_ready = ($urandom_range(0, 3) != 0);
      end
      req_valid = nxt_valid;
      req_op    = nxt_op;
      rsp_ready = nxt_ready;
      #1;
      for (int k = 0; k < NINST; k++) check_inst(k);
      m_cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0; nxt_valid = '0;
    rsp_ready = 1'b1; nxt_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    for (int k = 0; k < NINST; k++) begin
      check_cnt++;
      if ({rdy[k], rv[k], busy[k], rid[k], dst[k], dptr[k]} !== '0) $display("FAIL reset_ctrl inst%0d got %b exp 0", k, {rdy[k], rv[k], busy[k], rid[k], dst[k], dptr[k]});
      else pass_cnt++;
      check_cnt++;
      if (eop[k] !== '0) $display("FAIL reset_eval_op inst%0d got %h exp 0", k, eop[k]);
      else pass_cnt++;
      check_cnt++;
      if (ry[k] !== '0) $display("FAIL reset_rsp_y inst%0d got %h exp 0", k, ry[k]);
      else pass_cnt++;
      check_cnt++;
      if (stat[k] !== '0) $display("FAIL reset_stat inst%0d got %h exp 0", k, stat[k]);
      else pass_cnt++;
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [OP_W-1:0] op;
    op = 60'h0123456789ABCDE;
    do_reset();
    nxt_valid = 4'b0100;
    nxt_op[2*OP_W +: OP_W] = op;
    step(1, 0);
    check_cnt++;
    if (rdy[0] !== 4'b0100) $display("FAIL single_ready got %b exp 0100", rdy[0]);
    else pass_cnt++;
    nxt_valid = '0;
    step(1, 0);
    check_cnt++;
    if (eop[0] !== op || rv[0] !== 1'b0) $display("FAIL single_eval_op got %h/%b exp %h/0", eop[0], rv[0], op);
    else pass_cnt++;
    step(1, 0);
    check_cnt++;
    if (rv[0] !== 1'b1 || rid[0] !== 2'd2 || ry[0] !== eval_fn(op))
      $display("FAIL single_rsp got %b/%0d/%h exp 1/2/%h", rv[0], rid[0], ry[0], eval_fn(op));
    else pass_cnt++;
    step(1, 0);
    check_cnt++;
    if (rv[0] !== 1'b0) $display("FAIL single_rsp_drop got %b exp 0", rv[0]);
    else pass_cnt++;
    step(6, 0);
  endtask

  task automatic test_fairness();
    int sp;
    do_reset();
    nxt_valid = 4'b1111;
    nxt_ready = 1'b1;
    step(26, 1);
    for (int k = 0; k < 2; k++) begin
      sp = lat_c[k] + 2;
      check_cnt++;
      if (glog_n[k] < 5) $display("FAIL fair_count inst%0d got %0d exp >=5", k, glog_n[k]);
      else begin
        pass_cnt++;
        for (int j = 0; j < 5; j++) begin
          check_cnt++;
          if (glog_id[k][j] != j % NREQ) $display("FAIL fair_order inst%0d grant%0d got %0d exp %0d", k, j, glog_id[k][j], j % NREQ);
          else pass_cnt++;
          if (j > 0) begin
            check_cnt++;
            if (glog_cyc[k][j] - glog_cyc[k][j-1] != sp)
              $display("FAIL fair_spacing inst%0d grant%0d got %0d exp %0d", k, j, glog_cyc[k][j] - glog_cyc[k][j-1], sp);
            else pass_cnt++;
          end
        end
      end
    end
    nxt_valid = '0;
    step(8, 0);
  endtask

  task automatic test_backpressure();
    logic [1:0]       sid;
    logic [RES_W-1:0] sy;
    int               hs0, w;
    do_reset();
    nxt_valid = 4'b0010;
    nxt_ready = 1'b0;
    step(1, 1);
    nxt_valid = '0;
    w = 0;
    while (rv[0] !== 1'b1 && w < 10) begin
      step(1, 1);
      w++;
    end
    check_cnt++;
    if (rv[0] !== 1'b1) $display("FAIL bp_rsp_timeout got %b exp 1", rv[0]);
    else pass_cnt++;
    sid = rid[0];
    sy  = ry[0];
    hs0 = hs_cnt[0];
    nxt_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      check_cnt++;
      if (rv[0] !== 1'b1 || rid[0] !== sid || ry[0] !== sy || rdy[0] !== '0)
        $display("FAIL bp_hold cyc%0d got %b/%0d/%h/%b exp 1/%0d/%h/0000", i, rv[0], rid[0], ry[0], rdy[0], sid, sy);
      else pass_cnt++;
    end
    nxt_ready = 1'b1;
    step(1, 1);
    nxt_valid = '0;
    step(1, 1);
    check_cnt++;
    if (rv[0] !== 1'b0 || hs_cnt[0] - hs0 != 1) $display("FAIL bp_release got %b/%0d exp 0/1", rv[0], hs_cnt[0] - hs0);
    else pass_cnt++;
    step(8, 0);
  endtask

  task automatic test_reset_in_drive();
    do_reset();
    nxt_valid = 4'b0001;
    step(1, 1);
    nxt_valid = '0;
    step(2, 0);
    check_cnt++;
    if (busy[2] !== 1'b1) $display("FAIL rst_pre_busy got %b exp 1", busy[2]);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if ({busy[2], rv[2], rid[2], dst[2], dptr[2], eop[2], ry[2]} !== '0)
      $display("FAIL rst_async got %b/%b/%0d/%0d/%0d/%h/%h exp all 0", busy[2], rv[2], rid[2], dst[2], dptr[2], eop[2], ry[2]);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(8, 1);
    nxt_valid = 4'b1001;
    step(1, 1);
    check_cnt++;
    if (rdy[2] !== 4'b0001) $display("FAIL rst_regrant got %b exp 0001", rdy[2]);
    else pass_cnt++;
    nxt_valid = '0;
    step(8, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    nxt_valid = 4'b1000;
    step(1, 1);
    check_cnt++;
    if (rdy[0] !== 4'b1000) $display("FAIL wrap_grant3 got %b exp 1000", rdy[0]);
    else pass_cnt++;
    nxt_valid = '0;
    step(1, 1);
    check_cnt++;
    if (dptr[0] !== 2'd0) $display("FAIL wrap_ptr0 got %0d exp 0", dptr[0]);
    else pass_cnt++;
    step(2, 1);
    nxt_valid = 4'b0010;
    step(1, 1);
    check_cnt++;
    if (rdy[0] !== 4'b0010) $display("FAIL wrap_grant1 got %b exp 0010", rdy[0]);
    else pass_cnt++;
    nxt_valid = '0;
    step(1, 1);
    check_cnt++;
    if (dptr[0] !== 2'd2) $display("FAIL wrap_ptr2 got %0d exp 2", dptr[0]);
    else pass_cnt++;
    step(6, 0);
  endtask

  task automatic test_random();
    do_reset();
    step(400, 2);
    nxt_valid = '0;
    nxt_ready = 1'b1;
    step(10, 0);
    check_cnt++;
    if (hs_cnt[0] == 0) $display("FAIL rand_progress got %0d handshakes exp >0", hs_cnt[0]);
    else pass_cnt++;
  endtask

  task automatic test_stats();
    int guard;
    do_reset();
`ifdef EXPR_EVAL_SCHED_STATS_EN
    nxt_valid = 4'b0001;
    nxt_ready = 1'b1;
    guard = 0;
    while (acc0_cnt[0] < 65536 && guard < 250000) begin
      step(1, 1);
      guard++;
    end
    nxt_valid = '0;
    step(8, 0);
    check_cnt++;
    if (hs_cnt[0] != 65536) $display("FAIL stat_wrap_count got %0d exp 65536", hs_cnt[0]);
    else pass_cnt++;
    check_cnt++;
    if (stat[0] !== 64'h0) $display("FAIL stat_wrap got %h exp 0", stat[0]);
    else pass_cnt++;
`else
    guard = 0;
    step(120, 2);
    nxt_valid = '0;
    nxt_ready = 1'b1;
    step(8, 0);
    for (int k = 0; k < NINST; k++) begin
      guard += hs_cnt[k];
      check_cnt++;
      if (stat[k] !== 64'h0) $display("FAIL stat_off inst%0d got %h exp 0", k, stat[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (guard == 0) $display("FAIL stat_off_traffic got %0d handshakes exp >0", guard);
    else pass_cnt++;
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_in_drive();
    test_wrap();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
